hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single rising-edge clock.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: rsD, rtD  input  5 each  source register numbers of the instruction in D.
REQ-004 SHALL provide: tuse_rs, tuse_rt  input  2 each  cycles until D needs the operand (3 = unused).
REQ-005 SHALL provide: waE, waM  input  5 each  write register of the instructions in E and M (0 = none).
REQ-006 SHALL provide: tnewE, tnewM  input  2 each  cycles until the E/M result is forwardable.
REQ-007 SHALL provide: md_useD  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL provide: md_startE, md_divE  input  1 each  mult/div in E starts the unit; md_divE=1 selects divide.
REQ-009 SHALL provide: strange, eretM, xiao  input  1 each  exception in M, eret in M, branch-likely not taken in D.
REQ-010 SHALL provide: stall  output  1  freeze PC and IF/ID; insert a bubble into ID/EX.
REQ-011 SHALL provide: flush_all  output  1  clear IF/ID, ID/EX and EX/MEM.
REQ-012 SHALL provide: nullify  output  1  clear IF/ID (delay-slot kill).
REQ-013 SHALL provide: md_busy  output  1  multiply/divide unit occupied.
REQ-014 SHALL provide: md_cnt  output  4  remaining busy cycles.

Function
REQ-015 data stall SHALL assert when (rsD!=0, rsD==waE, tuse_rs<tnewE) or (rsD!=0, rsD==waM, tuse_rs<tnewM); same terms apply to rtD/tuse_rt.
REQ-016 md stall SHALL assert when md_useD and (md_busy or md_startE).
REQ-017 stall SHALL = (data stall or md stall) and not flush_all; combinational, zero latency.
REQ-018 flush_all SHALL = strange or eretM; combinational.
REQ-019 nullify SHALL = xiao and not stall and not flush_all.
REQ-020 Priority SHALL be flush_all > stall > nullify; at most one output of the three is high in any cycle.
REQ-021 FSM states SHALL be IDLE and BUSY.
REQ-022 IDLE->BUSY SHALL occur at the edge where md_startE=1 and flush_all=0; md_cnt loads 5 (mult) or 10 (div).
REQ-023 In BUSY, md_cnt SHALL decrement by 1 per cycle; at md_cnt==1 the next state is IDLE with md_cnt=0.
REQ-024 md_busy SHALL equal (state==BUSY); it is registered.
REQ-025 md_startE SHALL be ignored while the FSM is in BUSY; upstream never issues one, because REQ-016 stalls it.
REQ-026 md_startE coincident with flush_all SHALL be ignored, since the instruction is cancelled.
REQ-027 flush_all during BUSY SHALL NOT abort the countdown, since the started operation is committed.
REQ-028 md_cnt SHALL never wrap below 0.

Reset
REQ-029 On reset at a clk edge: state=IDLE, md_cnt=0, md_busy=0.
REQ-030 Reset SHALL override any in-progress countdown, including a mid-divide countdown.
REQ-031 stall, flush_all and nullify are combinational and SHALL remain input-driven during reset; pipeline registers apply their own reset priority.

Structure
REQ-032 Shared package hazard_pkg SHALL hold: MULT_CYCLES=5, DIV_CYCLES=10, TUSE_NONE=2'd3, and the FSM state type.
REQ-033 Sub-module md_busy_timer SHALL contain the FSM and md_cnt.
REQ-034 Stall, flush and nullify logic SHALL stay in the top level as pure combinational logic.
REQ-035 No other state SHALL exist in the block.

Verification
REQ-036 Load-use: waE=5, tnewE=2, rsD=5, tuse_rs=0 -> stall=1; the next cycle with tnewE=1, waM=5, tnewM=1 -> stall=1; then tnewM=0 -> stall=0.
REQ-037 $0 hazard: rsD=0, waE=0, tnewE=2, tuse_rs=0 -> stall=0.
REQ-038 Div then mflo: md_startE=1, md_divE=1 at cycle 0 -> md_busy=1 for cycles 1-10 with md_cnt 10..1; md_useD=1 -> stall=1 in cycles 0-10 and 0 in cycle 11.
REQ-039 Flush priority: strange=1 with a data hazard and xiao=1 present -> flush_all=1, stall=0, nullify=0.
REQ-040 Cancelled start: md_startE=1 with eretM=1 -> md_busy stays 0.
REQ-041 Mid-count events: at md_cnt=3, strange=1 -> countdown continues to 0; at md_cnt=7, reset=1 -> md_cnt=0 and md_busy=0 the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Holds the multiply/divide latencies and the busy-timer state type.
package hazard_pkg;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;
    localparam logic [1:0] TUSE_NONE   = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Number of busy cycles for the operation kind.
    function automatic logic [3:0] md_load(input logic div);
        return div ? DIV_CYCLES : MULT_CYCLES;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Multiply/divide occupancy timer.
// Counts down the cycles the unit stays busy after an accepted start.
module md_busy_timer
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       div,
    output logic       busy,
    output logic [3:0] cnt
);

    md_state_t  state;
    md_state_t  state_n;
    logic [3:0] cnt_n;

    // State and counter registers; reset wins over any countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: load on start, count down to zero, never below.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = BUSY;
                    cnt_n   = md_load(div);
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data/md stalls, flushes, delay-slot kill.
// Only the md busy timer holds state; everything else is combinational.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [1:0] tuse_rs,
    input  logic [1:0] tuse_rt,
    input  logic [4:0] waE,
    input  logic [4:0] waM,
    input  logic [1:0] tnewE,
    input  logic [1:0] tnewM,
    input  logic       md_useD,
    input  logic       md_startE,
    input  logic       md_divE,
    input  logic       strange,
    input  logic       eretM,
    input  logic       xiao,
    output logic       stall,
    output logic       flush_all,
    output logic       nullify,
    output logic       md_busy,
    output logic [3:0] md_cnt
);

    logic hz_rs;
    logic hz_rt;
    logic md_stall;

    // Operand needed before the in-flight producer can forward it.
    always_comb begin
        hz_rs = (rsD != 5'd0) &&
                (((rsD == waE) && (tuse_rs < tnewE)) ||
                 ((rsD == waM) && (tuse_rs < tnewM)));
        hz_rt = (rtD != 5'd0) &&
                (((rtD == waE) && (tuse_rt < tnewE)) ||
                 ((rtD == waM) && (tuse_rt < tnewM)));
    end

    // Priority: flush over stall over nullify.
    always_comb begin
        md_stall  = md_useD && (md_busy || md_startE);
        flush_all = strange || eretM;
        stall     = (hz_rs || hz_rt || md_stall) && !flush_all;
        nullify   = xiao && !stall && !flush_all;
    end

    // A start cancelled by a flush never occupies the unit.
    md_busy_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .start (md_startE && !flush_all),
        .div   (md_divE),
        .busy  (md_busy),
        .cnt   (md_cnt)
    );

endmodule
